// File: rtl/cam_pkg.sv
// rtl/cam_pkg.sv - shared CAM encoder defaults, state encoding and popcount helper
package cam_pkg;

    localparam int CAM_DEPTH_DEF  = 8;
    localparam int ADDR_WIDTH_DEF = 3;
    localparam int MAX_DEPTH      = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        EMPTY = 2'd2
    } state_e;

    // Callers zero-extend their vector to MAX_DEPTH bits.
    function automatic int unsigned popcount(input logic [MAX_DEPTH-1:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < MAX_DEPTH; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/cam_match_encoder_if.sv
// rtl/cam_match_encoder_if.sv - match-vector input and address-beat output handshake bundle
interface cam_match_encoder_if
    import cam_pkg::*;
#(
    parameter int CAM_DEPTH  = CAM_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
);
    logic                  match_valid;
    logic                  match_ready;
    logic [CAM_DEPTH-1:0]  decoded_match_address;
    logic                  addr_valid;
    logic                  addr_ready;
    logic [ADDR_WIDTH-1:0] match_address;
    logic                  addr_last;
    logic                  no_match;
    logic [ADDR_WIDTH:0]   match_count;

    modport master (
        output match_valid, decoded_match_address, addr_ready,
        input  match_ready, addr_valid, match_address, addr_last, no_match, match_count
    );

    modport slave (
        input  match_valid, decoded_match_address, addr_ready,
        output match_ready, addr_valid, match_address, addr_last, no_match, match_count
    );
endinterface

// File: rtl/cam_priority_encoder.sv
// rtl/cam_priority_encoder.sv - combinational find-first-set; CAM_MATCH_HIGH_FIRST_EN selects highest bit first
module cam_priority_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [IDX_W-1:0] idx_o,
    output logic             any_o
);
    // The last matching iteration wins, so loop order sets the priority.
    always_comb begin
        idx_o = '0;
        any_o = |vec_i;
`ifdef CAM_MATCH_HIGH_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) idx_o = IDX_W'(i);
        end
`endif
    end
endmodule

// File: rtl/cam_match_encoder.sv
// rtl/cam_match_encoder.sv - serialises a multi-hot CAM match vector into binary row-address beats
// Scan order follows CAM_MATCH_HIGH_FIRST_EN (via cam_priority_encoder).
module cam_match_encoder
    import cam_pkg::*;
#(
    parameter int CAM_DEPTH  = CAM_DEPTH_DEF,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                rst,
    cam_match_encoder_if.slave  bus
);
    state_e                state_q;
    logic [CAM_DEPTH-1:0]  pending_q, pending_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH:0]   count_q;
    logic                  ready_q, valid_q, last_q, nm_q;

    logic [ADDR_WIDTH-1:0] nxt_idx;
    logic                  nxt_any;
    logic                  nxt_single;
    logic [ADDR_WIDTH:0]   nxt_count;

    // Outputs are registered, so the encoder looks ahead at the vector the next beat will see.
    always_comb begin
        pending_d = pending_q;
        if (state_q == IDLE) begin
            pending_d = bus.decoded_match_address;
        end else if (state_q == SCAN) begin
            pending_d = pending_q & ~(CAM_DEPTH'(1) << addr_q);
        end
    end

    assign nxt_count  = (ADDR_WIDTH+1)'(popcount(MAX_DEPTH'(pending_d)));
    assign nxt_single = (nxt_count == (ADDR_WIDTH+1)'(1));

    cam_priority_encoder #(
        .WIDTH (CAM_DEPTH),
        .IDX_W (ADDR_WIDTH)
    ) u_prio (
        .vec_i (pending_d),
        .idx_o (nxt_idx),
        .any_o (nxt_any)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            addr_q    <= '0;
            count_q   <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            last_q    <= 1'b0;
            nm_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.match_valid) begin
                        pending_q <= pending_d;
                        count_q   <= nxt_count;
                        ready_q   <= 1'b0;
                        valid_q   <= 1'b1;
                        if (nxt_any) begin
                            state_q <= SCAN;
                            addr_q  <= nxt_idx;
                            last_q  <= nxt_single;
                            nm_q    <= 1'b0;
                        end else begin
                            state_q <= EMPTY;
                            addr_q  <= '0;
                            last_q  <= 1'b1;
                            nm_q    <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    if (bus.addr_ready) begin
                        pending_q <= pending_d;
                        if (last_q) begin
                            state_q <= IDLE;
                            ready_q <= 1'b1;
                            valid_q <= 1'b0;
                            addr_q  <= '0;
                            last_q  <= 1'b0;
                        end else begin
                            addr_q <= nxt_idx;
                            last_q <= nxt_single;
                        end
                    end
                end
                EMPTY: begin
                    if (bus.addr_ready) begin
                        state_q <= IDLE;
                        ready_q <= 1'b1;
                        valid_q <= 1'b0;
                        last_q  <= 1'b0;
                        nm_q    <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.match_ready   = ready_q;
    assign bus.addr_valid    = valid_q;
    assign bus.match_address = addr_q;
    assign bus.addr_last     = last_q;
    assign bus.no_match      = nm_q;
    assign bus.match_count   = count_q;
endmodule
